// File: rtl/matrix_elem_sender.sv
// matrix_elem_sender
//   Formats one signed matrix element as decimal ASCII and streams it, one
//   byte at a time, to a UART TX byte transmitter. Three request types:
//     normal       : ['-'] digits (SEP_CHAR | EOL_CHAR)
//     is_id        : ID_CHAR digits EOL_CHAR
//     newline_only : EOL_CHAR
//   Leading zeros are suppressed; zero prints as "0".
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   data              signed element (ELEM_W bits), latched on accepted start
//   start             request pulse, accepted only while ready=1
//   is_last_col       latched with start; selects EOL_CHAR as terminator
//   newline_only      latched with start; send EOL_CHAR only
//   is_id             latched with start; '#'-prefixed ID line
//   ready             idle and able to accept start
//   done              one-cycle pulse after the last byte's tx_done
//   tx_data/tx_start  byte and launch pulse toward the UART
//   tx_ready/tx_done  UART idle flag and per-byte completion pulse

module matrix_elem_sender #(
  parameter int          ELEM_W   = 8,
  parameter logic [7:0]  SEP_CHAR = 8'h20,
  parameter logic [7:0]  EOL_CHAR = 8'h0A,
  parameter logic [7:0]  ID_CHAR  = 8'h23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ELEM_W-1:0] data,
  input  logic              start,
  input  logic              is_last_col,
  input  logic              newline_only,
  input  logic              is_id,
  output logic              ready,
  output logic              done,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_ready,
  input  logic              tx_done
);

  // Magnitude is one bit wider than the element so the most negative value
  // (e.g. -128 -> 128) is representable. Comparisons against the decimal
  // powers happen at 17 bits, wide enough for 10000 and for ELEM_W=16.
  localparam int MAG_W = ELEM_W + 1;
  localparam int CMP_W = 17;

  typedef enum logic [2:0] {
    S_IDLE, S_BUILD, S_CONV, S_ISSUE, S_WAIT_TX, S_FINISH
  } state_t;

  state_t            state;
  logic [ELEM_W-1:0] data_q;
  logic              last_q, nl_q, id_q;
  logic [7:0]        byte_buf [8];
  logic [3:0]        wr_cnt;
  logic [3:0]        rd_ptr;
  logic [MAG_W-1:0]  mag_q;
  logic [2:0]        pow_idx;
  logic [3:0]        digit_q;
  logic              seen_q;

  function automatic logic [CMP_W-1:0] pow10(input logic [2:0] idx);
    case (idx)
      3'd0:    pow10 = 17'd10000;
      3'd1:    pow10 = 17'd1000;
      3'd2:    pow10 = 17'd100;
      3'd3:    pow10 = 17'd10;
      default: pow10 = 17'd1;
    endcase
  endfunction

  logic [MAG_W-1:0] data_ext;
  logic [MAG_W-1:0] mag_abs;
  logic [CMP_W-1:0] mag_ext;
  logic [CMP_W-1:0] pow_cur;
  logic             push_dig;
  logic [7:0]       dig_ascii;
  logic [7:0]       term_char;
  logic [2:0]       term_idx;

  always_comb begin
    data_ext  = {data_q[ELEM_W-1], data_q};
    mag_abs   = data_q[ELEM_W-1] ? (~data_ext + MAG_W'(1)) : data_ext;
    mag_ext   = CMP_W'(mag_q);
    pow_cur   = pow10(pow_idx);
    // Emit a digit once a nonzero digit has been seen, or always for ones.
    push_dig  = (digit_q != 4'd0) || seen_q || (pow_idx == 3'd4);
    dig_ascii = 8'h30 + {4'h0, digit_q};
    term_char = (id_q || last_q) ? EOL_CHAR : SEP_CHAR;
    term_idx  = wr_cnt[2:0] + 3'd1;
  end

  // ready is decoded from the state register; it is forced low while rst is
  // high so it is 0 during reset and 1 on the first cycle after release.
  assign ready = (state == S_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      data_q   <= '0;
      last_q   <= 1'b0;
      nl_q     <= 1'b0;
      id_q     <= 1'b0;
      wr_cnt   <= '0;
      rd_ptr   <= '0;
      mag_q    <= '0;
      pow_idx  <= '0;
      digit_q  <= '0;
      seen_q   <= 1'b0;
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
      done     <= 1'b0;
      for (int i = 0; i < 8; i++) byte_buf[i] <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            data_q <= data;
            last_q <= is_last_col;
            nl_q   <= newline_only;
            id_q   <= is_id;
            state  <= S_BUILD;
          end
        end

        S_BUILD: begin
          rd_ptr  <= '0;
          pow_idx <= '0;
          digit_q <= '0;
          seen_q  <= 1'b0;
          mag_q   <= mag_abs;
          if (nl_q) begin
            byte_buf[0] <= EOL_CHAR;
            wr_cnt      <= 4'd1;
            state       <= S_ISSUE;
          end else if (id_q) begin
            byte_buf[0] <= ID_CHAR;
            wr_cnt      <= 4'd1;
            state       <= S_CONV;
          end else if (data_q[ELEM_W-1]) begin
            byte_buf[0] <= 8'h2D;
            wr_cnt      <= 4'd1;
            state       <= S_CONV;
          end else begin
            wr_cnt      <= 4'd0;
            state       <= S_CONV;
          end
        end

        // One subtraction per cycle; when the remainder drops below the
        // current power the digit is final and we step to the next power.
        S_CONV: begin
          if (mag_ext >= pow_cur) begin
            mag_q   <= MAG_W'(mag_ext - pow_cur);
            digit_q <= digit_q + 4'd1;
          end else begin
            if (push_dig) byte_buf[wr_cnt[2:0]] <= dig_ascii;
            seen_q  <= seen_q | (digit_q != 4'd0);
            digit_q <= '0;
            if (pow_idx == 3'd4) begin
              // ones digit is always pushed, so terminator lands right after
              byte_buf[term_idx] <= term_char;
              wr_cnt             <= wr_cnt + 4'd2;
              state              <= S_ISSUE;
            end else begin
              wr_cnt  <= wr_cnt + {3'b000, push_dig};
              pow_idx <= pow_idx + 3'd1;
            end
          end
        end

        S_ISSUE: begin
          if (tx_ready) begin
            tx_data  <= byte_buf[rd_ptr[2:0]];
            tx_start <= 1'b1;
            state    <= S_WAIT_TX;
          end
        end

        // done is raised on entry to FINISH so it is seen while ready is
        // still low; ready rises the cycle after.
        S_WAIT_TX: begin
          if (tx_done) begin
            if (rd_ptr == wr_cnt - 4'd1) begin
              done  <= 1'b1;
              state <= S_FINISH;
            end else begin
              rd_ptr <= rd_ptr + 4'd1;
              state  <= S_ISSUE;
            end
          end
        end

        S_FINISH: state <= S_IDLE;

        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_elem_sender.sv
module tb_matrix_elem_sender;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       start, is_last_col, newline_only, is_id;
  logic       ready, done;
  logic [7:0] tx_data;
  logic       tx_start, tx_ready, tx_done;

  logic       tx_en;
  int         tx_cnt;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         exp_done = 0;
  int         done_seen = 0;
  int         txs_seen = 0;
  bit         chk_rdy_next = 0;

  always #5 clk = ~clk;

  matrix_elem_sender #(.ELEM_W(8)) dut (
    .clk(clk), .rst(rst), .data(data), .start(start),
    .is_last_col(is_last_col), .newline_only(newline_only), .is_id(is_id),
    .ready(ready), .done(done), .tx_data(tx_data), .tx_start(tx_start),
    .tx_ready(tx_ready), .tx_done(tx_done)
  );

  // UART TX model: busy for 3 cycles after a launch, then one tx_done pulse.
  assign tx_ready = tx_en && (tx_cnt == 0) && !tx_done;

  always @(posedge clk) begin
    tx_done <= 1'b0;
    if (tx_cnt > 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) tx_done <= 1'b1;
    end else if (tx_start) begin
      tx_cnt <= 3;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every launched byte and every done pulse.
  initial forever begin
    @(negedge clk);
    if (chk_rdy_next) begin
      chk("ready_after_done", {31'd0, ready}, 32'd1);
      chk_rdy_next = 0;
    end
    if (tx_start === 1'b1) begin
      txs_seen++;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_tx_byte: got 0x%0h expected none", tx_data);
      end else begin
        chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
    end
    if (done === 1'b1) begin
      if (exp_done == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done: got 1 expected 0");
      end else begin
        exp_done--;
        chk("bytes_left_at_done", exp_q.size(), 0);
        chk("ready_low_at_done", {31'd0, ready}, 32'd0);
      end
      done_seen++;
      chk_rdy_next = 1;
    end
  end

  task automatic issue_start(input logic [7:0] d, input logic last, input logic nl, input logic id);
    int n = 0;
    while (ready !== 1'b1 && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 500) chk("ready_timeout", 32'd0, 32'd1);
    data = d; is_last_col = last; newline_only = nl; is_id = id; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // scramble inputs after acceptance; the request must be unaffected
    data = 8'h55; is_last_col = ~last; newline_only = ~nl; is_id = ~id;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_seen < target && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 2000) chk("done_timeout", done_seen, target);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last, input logic nl,
                      input logic id, input logic [7:0] bytes[$]);
    foreach (bytes[i]) exp_q.push_back(bytes[i]);
    exp_done++;
    issue_start(d, last, nl, id);
    wait_done(done_seen + 1);
  endtask

  initial begin
    int base;
    int n;
    bit bad;
    rst = 1'b1; start = 1'b0; data = '0;
    is_last_col = 1'b0; newline_only = 1'b0; is_id = 1'b0;
    tx_en = 1'b1; tx_cnt = 0; tx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_tx_start", {31'd0, tx_start}, 32'd0);
    chk("reset_tx_data", {24'd0, tx_data}, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {31'd0, ready}, 32'd1);

    // 1: zero, separator
    send(8'd0, 1'b0, 1'b0, 1'b0, '{8'h30, 8'h20});
    // 2: most negative, end of line
    send(8'h80, 1'b1, 1'b0, 1'b0, '{8'h2D, 8'h31, 8'h32, 8'h38, 8'h0A});
    // 3: ID line forces EOL, then a plain 127
    send(8'd5, 1'b0, 1'b0, 1'b1, '{8'h23, 8'h35, 8'h0A});
    send(8'd127, 1'b0, 1'b0, 1'b0, '{8'h31, 8'h32, 8'h37, 8'h20});
    // 105: interior zero must print
    send(8'd105, 1'b1, 1'b0, 1'b0, '{8'h31, 8'h30, 8'h35, 8'h0A});
    // 4: newline_only wins over is_id
    send(8'd77, 1'b0, 1'b1, 1'b1, '{8'h0A});

    // 5: UART not ready for 50 cycles, stray start mid-request
    tx_en = 1'b0;
    exp_q.push_back(8'h33); exp_q.push_back(8'h0A); exp_done++;
    base = txs_seen;
    issue_start(8'd3, 1'b1, 1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 20) begin data = 8'hFF; start = 1'b1; end
      if (i == 21) start = 1'b0;
      @(posedge clk); #1;
      if (tx_start !== 1'b0) bad = 1;
    end
    chk("no_tx_start_while_busy", {31'd0, bad}, 32'd0);
    tx_en = 1'b1;
    wait_done(done_seen + 1);
    repeat (10) @(posedge clk);
    #1;
    chk("byte_count_stray_start", txs_seen - base, 2);

    // 6: reset while waiting for the second byte of -45
    exp_q.push_back(8'h2D); exp_q.push_back(8'h34);
    base = txs_seen;
    issue_start(8'hD3, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (txs_seen < base + 2 && n < 500) begin
      @(negedge clk); n++;
    end
    if (n >= 500) chk("second_byte_timeout", txs_seen - base, 2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_in_mid_reset", {31'd0, ready}, 32'd0);
    chk("tx_start_in_mid_reset", {31'd0, tx_start}, 32'd0);
    chk("done_in_mid_reset", {31'd0, done}, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_mid_reset", {31'd0, ready}, 32'd1);
    chk("bytes_before_mid_reset", exp_q.size(), 0);
    repeat (8) @(posedge clk);
    #1;
    chk("no_tx_after_stray_done", txs_seen - base, 2);
    send(8'd9, 1'b0, 1'b0, 1'b0, '{8'h39, 8'h20});

    repeat (10) @(posedge clk);
    #1;
    chk("final_bytes_pending", exp_q.size(), 0);
    chk("final_done_pending", exp_done, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_elem_sender.md
Name: matrix_elem_sender

Overview:
- Downstream formatter and transmitter for the matrix input echo path and other print paths.
- Accepts one signed matrix element per start pulse and converts it to decimal ASCII.
- Appends a column separator or end-of-line byte, then feeds the bytes one at a time to the UART TX byte transmitter.
- Reports completion with a one-cycle done pulse and a level ready flag.

Parameters:
ELEM_W, 8, width of the signed element input (legal 2..16)
SEP_CHAR, 8'h20, separator byte sent after a non-last-column element
EOL_CHAR, 8'h0A, end-of-line byte
ID_CHAR, 8'h23, prefix byte for an ID print

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
data  in  ELEM_W  signed element to print; sampled on accepted start
start  in  1  request pulse; accepted only when ready=1
is_last_col  in  1  sampled with start; 1 selects EOL_CHAR instead of SEP_CHAR
newline_only  in  1  sampled with start; send EOL_CHAR only
is_id  in  1  sampled with start; print as ID line
ready  out  1  high while idle and able to accept start
done  out  1  one-cycle pulse when the last byte of a request completes
tx_data  out  8  byte to transmit; stable from tx_start until tx_done
tx_start  out  1  one-cycle pulse launching tx_data
tx_ready  in  1  UART TX idle; tx_start is issued only when 1
tx_done  in  1  one-cycle pulse: current byte fully sent

Behaviour:
- Reset values: ready=0 during rst, 1 on the first cycle after; done=0, tx_start=0, tx_data=0. FSM in IDLE, byte buffer empty.
- States: IDLE, BUILD, CONV, ISSUE, WAIT_TX, FINISH.
- IDLE: ready=1. When start=1, latch data and the three flags, set ready=0 next cycle, go to BUILD. start in any other state is ignored (no queueing).
- BUILD: load an 8-entry byte buffer with count wr_cnt, using precedence newline_only > is_id > normal.
  - newline_only: buffer={EOL_CHAR}; skip to ISSUE.
  - is_id: push ID_CHAR.
  - normal with data<0: push 8'h2D ('-').
  - Then compute magnitude as an (ELEM_W+1)-bit unsigned value, so that the most negative value is magnitude 2^(ELEM_W-1) (e.g. 128 at ELEM_W=8). Go to CONV.
- CONV: digit extraction by repeated subtraction, powers 10000, 1000, 100, 10, 1 in order; at most one subtraction per cycle.
  - A digit is pushed as 8'h30+d only once a nonzero digit has appeared, or when the power is 1. Hence 0 prints as "0" and there are no leading zeros.
  - After the ones digit, push the terminator: EOL_CHAR if is_id or is_last_col, else SEP_CHAR. Go to ISSUE.
  - At most 8 bytes total (prefix/sign + 5 digits + terminator); overflow is impossible by construction.
- ISSUE: when tx_ready=1, drive tx_data=buf[rd_ptr] and pulse tx_start for exactly one cycle, then go to WAIT_TX. If tx_ready=0, hold in ISSUE with tx_start=0.
- WAIT_TX: on tx_done, increment rd_ptr. If rd_ptr==wr_cnt-1, go to FINISH; otherwise go to ISSUE. Only one byte is outstanding at any time.
- FINISH: done=1 for one cycle, go to IDLE; ready=1 from the following cycle.
  - Upstream can issue the next start on the cycle after done.
  - Minimum gap between consecutive tx_start pulses is 1 cycle after tx_done.
- tx_done received outside WAIT_TX is ignored.
- Reset mid-operation: immediate return to IDLE, buffer cleared, no done pulse. Any byte already launched completes in the TX module; its tx_done is ignored.
- Latched inputs are held for the whole request; changes to data or flags after acceptance have no effect.

Test Plan:
1. data=0, is_last_col=0; tx_done returned 3 cycles after each tx_start -> bytes 0x30,0x20; one done pulse; ready=1 the cycle after done.
2. data=-128, is_last_col=1 -> bytes 0x2D,0x31,0x32,0x38,0x0A in order; no leading zeros; done once.
3. is_id=1, data=5, is_last_col=0 -> bytes 0x23,0x35,0x0A (EOL forced); then data=127, is_last_col=0 -> 0x31,0x32,0x37,0x20.
4. newline_only=1, is_id=1, data=77 -> single byte 0x0A, done pulse; no digits emitted.
5. tx_ready held low 50 cycles after start -> tx_start stays 0 until tx_ready=1; a second start pulsed mid-request -> ignored, byte count unchanged.
6. rst asserted in WAIT_TX of the 2nd byte of -45 -> next cycle tx_start=0, done=0, ready=1 after release; a stray tx_done is ignored; a new start with data=9 -> bytes 0x39,0x20.
